// File: rtl/frame_writer_if.sv
// frame_writer_if: groups the pixel/header input side and the memory-write
// output side of frame_writer into one bundle.
//
// Handshake: there is no ready signal. pix_valid is a one-cycle strobe that
// carries exactly one pixel; the sink always takes it. hdr_valid is a level
// that frames the whole image. wr_en is a one-cycle write strobe, and
// wr_addr/wr_data/sof/eol/eof are meaningful (and non-zero) only while
// wr_en = 1.
//
// Modports:
//   master - the upstream parser / memory side (drives pixels, sees writes)
//   slave  - the frame_writer itself
interface frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic              pix_valid;
  logic [15:0]       height;
  logic [15:0]       width;
  logic              hdr_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              sof;
  logic              eol;
  logic              eof;
  logic              frame_done;
  logic              dim_error;
  logic              overflow;

  modport master (
    output pix_r, pix_g, pix_b, pix_valid, height, width, hdr_valid,
    input  wr_en, wr_addr, wr_data, sof, eol, eof, frame_done, dim_error, overflow
  );

  modport slave (
    input  pix_r, pix_g, pix_b, pix_valid, height, width, hdr_valid,
    output wr_en, wr_addr, wr_data, sof, eol, eof, frame_done, dim_error, overflow
  );
endinterface

// File: rtl/frame_writer.sv
// frame_writer: pixel sink behind the byte-stream parser. Tracks the raster
// position of each incoming pixel, converts it to RGB565 (GRAY = 0) or 8-bit
// luma (GRAY = 1) and issues one linear-address write per pixel. Flags
// start/end of line/frame, frame completion and protocol errors.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high
//   bus       - frame_writer_if.slave: pixel/header inputs, write outputs
//   state_dbg - current FSM state (0 IDLE, 1 RUN, 2 DONE, 3 ERROR)
//
// Pipeline: a pixel sampled at edge N is captured (stage 1), converted at
// N+1 (stage 2) and presented on the write port after edge N+2.
module frame_writer #(
  parameter int ADDR_W     = 19,
  parameter int MAX_PIXELS = 307200,
  parameter int GRAY       = 0
) (
  input  logic          clk,
  input  logic          reset,
  frame_writer_if.slave bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [31:0] MAX_P = 32'(MAX_PIXELS);

  state_t            state_q;
  state_t            state_d;

  logic [15:0]       w_q;
  logic [15:0]       h_q;
  logic [15:0]       x_q;
  logic [15:0]       y_q;
  logic [ADDR_W-1:0] addr_q;

  logic [31:0]       product;
  logic              dims_ok;
  logic              last_x;
  logic              last_y;

  logic              start_frame;
  logic              accept;
  logic              surplus;

  logic              s1_valid;
  logic [7:0]        s1_r;
  logic [7:0]        s1_g;
  logic [7:0]        s1_b;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_sof;
  logic              s1_eol;
  logic              s1_eof;

  logic              s2_valid;
  logic [15:0]       s2_data;
  logic [ADDR_W-1:0] s2_addr;
  logic              s2_sof;
  logic              s2_eol;
  logic              s2_eof;

  logic [15:0]       luma_sum;
  logic [15:0]       conv;

  assign product   = 32'(bus.width) * 32'(bus.height);
  assign dims_ok   = (bus.width != '0) && (bus.height != '0) && (product <= MAX_P);
  assign last_x    = (x_q == w_q - 16'd1);
  assign last_y    = (y_q == h_q - 16'd1);
  assign state_dbg = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Dropping hdr_valid always returns to IDLE, even on
  // the edge that accepts the last pixel; that pixel still drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.hdr_valid) state_d = dims_ok ? ST_RUN : ST_ERROR;
      end
      ST_RUN: begin
        if (!bus.hdr_valid)                       state_d = ST_IDLE;
        else if (bus.pix_valid && last_x && last_y) state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (!bus.hdr_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_frame = 1'b0;
    accept      = 1'b0;
    surplus     = 1'b0;
    case (state_q)
      ST_IDLE:           start_frame = bus.hdr_valid;
      ST_RUN:            accept      = bus.pix_valid;
      ST_DONE, ST_ERROR: surplus     = bus.pix_valid;
      default: ;
    endcase
  end

  // Raster position and linear address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q    <= '0;
      h_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (start_frame) begin
      w_q    <= bus.width;
      h_q    <= bus.height;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (last_x) begin
        x_q <= '0;
        y_q <= y_q + 16'd1;
      end else begin
        x_q <= x_q + 16'd1;
      end
    end
  end

  // Stage 1: capture the pixel together with its address and tags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_addr  <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_r     <= bus.pix_r;
      s1_g     <= bus.pix_g;
      s1_b     <= bus.pix_b;
      s1_addr  <= addr_q;
      s1_sof   <= (x_q == '0) && (y_q == '0);
      s1_eol   <= last_x;
      s1_eof   <= last_x && last_y;
    end
  end

  // Colour conversion. The luma weights sum to 256, so the 16-bit sum never
  // overflows and its top byte is the 8-bit luma.
  always_comb begin
    luma_sum = 16'd77 * {8'd0, s1_r} + 16'd150 * {8'd0, s1_g} + 16'd29 * {8'd0, s1_b};
    conv     = {s1_r[7:3], s1_g[7:2], s1_b[7:3]};
    if (GRAY != 0) conv = {8'd0, luma_sum[15:8]};
  end

  // Stage 2: converted pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_addr  <= '0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_data  <= conv;
      s2_addr  <= s1_addr;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
    end
  end

  // Write port: payload and tags are forced to zero between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.sof     <= 1'b0;
      bus.eol     <= 1'b0;
      bus.eof     <= 1'b0;
    end else begin
      bus.wr_en   <= s2_valid;
      bus.wr_addr <= s2_valid ? s2_addr : '0;
      bus.wr_data <= s2_valid ? s2_data : '0;
      bus.sof     <= s2_valid && s2_sof;
      bus.eol     <= s2_valid && s2_eol;
      bus.eof     <= s2_valid && s2_eof;
    end
  end

  // Status flags: all three are cleared only when a new frame starts.
  // frame_done rises together with the eof write, not when the FSM enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.frame_done <= 1'b0;
      bus.dim_error  <= 1'b0;
      bus.overflow   <= 1'b0;
    end else if (start_frame) begin
      bus.frame_done <= 1'b0;
      bus.dim_error  <= !dims_ok;
      bus.overflow   <= 1'b0;
    end else begin
      if (s2_valid && s2_eof) bus.frame_done <= 1'b1;
      if (surplus)            bus.overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: drives an RGB565 instance and a luma instance of
// frame_writer with identical stimulus and compares every write against a
// raster model computed from pixel index arithmetic.
//
// Write record per instance (40 bits):
//   [39] wr_en [38] frame_done [37] sof [36] eol [35] eof [34:16] addr [15:0] data
// Combined record: {rgb instance, luma instance}.
module tb_frame_writer;
  localparam int W = 80;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  frame_writer_if #(.ADDR_W(19)) bus0 ();
  frame_writer_if #(.ADDR_W(19)) bus1 ();

  frame_writer #(.ADDR_W(19), .MAX_PIXELS(307200), .GRAY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .state_dbg(st0)
  );
  frame_writer #(.ADDR_W(19), .MAX_PIXELS(307200), .GRAY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(st1)
  );

  logic [41:0] out0, out1;
  assign out0 = {bus0.wr_en, bus0.wr_addr, bus0.wr_data, bus0.sof, bus0.eol, bus0.eof,
                 bus0.frame_done, bus0.dim_error, bus0.overflow};
  assign out1 = {bus1.wr_en, bus1.wr_addr, bus1.wr_data, bus1.sof, bus1.eol, bus1.eof,
                 bus1.frame_done, bus1.dim_error, bus1.overflow};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc;
  int fw, fh, fidx;
  bit f_ok;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc_q[$];

  // ---------------- clock/reset bookkeeping ----------------
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every write cycle of either instance
  always @(negedge clk) begin
    if (bus0.wr_en || bus1.wr_en) begin
      got_q.push_back({bus0.wr_en, bus0.frame_done, bus0.sof, bus0.eol, bus0.eof, bus0.wr_addr, bus0.wr_data,
                       bus1.wr_en, bus1.frame_done, bus1.sof, bus1.eol, bus1.eof, bus1.wr_addr, bus1.wr_data});
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected write for pixel number idx of a w x h raster.
  function automatic logic [W-1:0] model_rec(input int r, input int g, input int b,
                                             input int idx, input int w, input int h);
    int x, rgb, luma;
    bit s, el, ef;
    x    = idx % w;
    s    = (idx == 0);
    el   = (x == w - 1);
    ef   = (idx == w * h - 1);
    rgb  = (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
    luma = (77 * r + 150 * g + 29 * b) / 256;
    return {1'b1, ef, s, el, ef, idx[18:0], rgb[15:0],
            1'b1, ef, s, el, ef, idx[18:0], luma[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus0.pix_valid = 1'b0;
      bus1.pix_valid = 1'b0;
    end
  endtask

  task automatic frame_begin(input int w, input int h);
    @(negedge clk);
    bus0.pix_valid = 1'b0; bus1.pix_valid = 1'b0;
    bus0.width = w[15:0];  bus1.width = w[15:0];
    bus0.height = h[15:0]; bus1.height = h[15:0];
    bus0.hdr_valid = 1'b1; bus1.hdr_valid = 1'b1;
    fw = w; fh = h; fidx = 0;
    f_ok = (w != 0) && (h != 0) && (longint'(w) * longint'(h) <= 64'd307200);
  endtask

  task automatic pix(input int r, input int g, input int b);
    @(negedge clk);
    bus0.pix_r = r[7:0]; bus0.pix_g = g[7:0]; bus0.pix_b = b[7:0]; bus0.pix_valid = 1'b1;
    bus1.pix_r = r[7:0]; bus1.pix_g = g[7:0]; bus1.pix_b = b[7:0]; bus1.pix_valid = 1'b1;
    strobe_cyc = cyc + 1;
    if (f_ok && fidx < fw * fh) exp_q.push_back(model_rec(r, g, b, fidx, fw, fh));
    fidx++;
  endtask

  task automatic rand_pix();
    pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic frame_end();
    drive_idle(4);
    @(negedge clk);
    bus0.hdr_valid = 1'b0; bus1.hdr_valid = 1'b0;
    drive_idle(2);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out0 !== '0) begin errors++; $display("FAIL reset_out_rgb got %h exp 0", out0); end
    checks++; if (out1 !== '0) begin errors++; $display("FAIL reset_out_gray got %h exp 0", out1); end
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st0); end
    reset = 1'b0;
    drive_idle(2);
  endtask

  task automatic test_2x2();
    logic [15:0] k[4];
    k[0] = 16'hF81F; k[1] = 16'h07E0; k[2] = 16'hFFFF; k[3] = 16'h0000;
    clear_sb();
    frame_begin(2, 2);
    pix(8'hFF, 8'h00, 8'hFF); pix(8'h00, 8'hFF, 8'h00);
    pix(8'hFF, 8'hFF, 8'hFF); pix(8'h00, 8'h00, 8'h00);
    frame_end();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL 2x2_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL 2x2_write%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_q[i][55:40] !== k[i]) begin errors++; $display("FAIL 2x2_data%0d got %h exp %h", i, got_q[i][55:40], k[i]); end
    end
    checks++; if (bus0.frame_done !== 1'b1) begin errors++; $display("FAIL 2x2_frame_done_hold got %b exp 1", bus0.frame_done); end
    checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL 2x2_overflow got %b exp 0", bus0.overflow); end
  endtask

  task automatic test_gray();
    logic [15:0] k[2];
    int rr[2], gg[2], bb[2];
    k[0] = 16'h00FF; k[1] = 16'h001D;
    rr[0] = 8'hFF; gg[0] = 8'hFF; bb[0] = 8'hFF;
    rr[1] = 8'h10; gg[1] = 8'h20; bb[1] = 8'h30;
    for (int f = 0; f < 2; f++) begin
      clear_sb();
      frame_begin(1, 1);
      pix(rr[f], gg[f], bb[f]);
      frame_end();
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL gray%0d_count got %0d exp 1", f, got_q.size()); end
      if (got_q.size() > 0) begin
        checks++; if (got_q[0][15:0] !== k[f]) begin errors++; $display("FAIL gray%0d_data got %h exp %h", f, got_q[0][15:0], k[f]); end
        checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL gray%0d_write got %h exp %h", f, got_q[0], exp_q[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    clear_sb();
    frame_begin(3, 2);
    rand_pix();
    first = strobe_cyc;
    repeat (5) rand_pix();
    frame_end();
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_cyc_q[i] != first + 2 + i) begin errors++; $display("FAIL b2b_cycle%0d got %0d exp %0d", i, got_cyc_q[i], first + 2 + i); end
    end
    if (got_q.size() == 6) begin
      checks++; if ({got_q[2][76], got_q[5][76]} !== 2'b11) begin errors++; $display("FAIL b2b_eol got %b exp 11", {got_q[2][76], got_q[5][76]}); end
    end
  endtask

  task automatic test_surplus();
    clear_sb();
    frame_begin(2, 2);
    repeat (5) rand_pix();
    frame_end();
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL surplus_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL surplus_write%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if ({bus0.overflow, bus1.overflow} !== 2'b11) begin errors++; $display("FAIL surplus_overflow got %b exp 11", {bus0.overflow, bus1.overflow}); end
    checks++; if (bus0.frame_done !== 1'b1) begin errors++; $display("FAIL surplus_frame_done got %b exp 1", bus0.frame_done); end
    frame_begin(2, 2);
    drive_idle(1);
    checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL surplus_ovf_clear got %b exp 0", bus0.overflow); end
    checks++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL surplus_fd_clear got %b exp 0", bus0.frame_done); end
    frame_end();
  endtask

  task automatic test_bad_dims();
    int bw[3], bh[3];
    bw[0] = 0; bh[0] = 5; bw[1] = 5; bh[1] = 0; bw[2] = 641; bh[2] = 480;
    for (int t = 0; t < 3; t++) begin
      clear_sb();
      frame_begin(bw[t], bh[t]);
      repeat (3) rand_pix();
      drive_idle(2);
      checks++; if (bus0.dim_error !== 1'b1) begin errors++; $display("FAIL baddim%0d_flag got %b exp 1", t, bus0.dim_error); end
      checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL baddim%0d_state got %0d exp 3", t, st0); end
      checks++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL baddim%0d_overflow got %b exp 1", t, bus0.overflow); end
      frame_end();
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL baddim%0d_writes got %0d exp 0", t, got_q.size()); end
      checks++; if (bus0.dim_error !== 1'b1) begin errors++; $display("FAIL baddim%0d_hold got %b exp 1", t, bus0.dim_error); end
    end
    // Largest legal frame is accepted; abort it after three pixels.
    clear_sb();
    frame_begin(640, 480);
    drive_idle(1);
    checks++; if (bus0.dim_error !== 1'b0) begin errors++; $display("FAIL maxdim_flag got %b exp 0", bus0.dim_error); end
    checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL maxdim_state got %0d exp 1", st0); end
    repeat (3) rand_pix();
    frame_end();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL maxdim_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxdim_write%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL abort_frame_done got %b exp 0", bus0.frame_done); end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    clear_sb();
    frame_begin(4, 4);
    rand_pix(); rand_pix();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #2;
      seen = bus0.wr_en;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_wait got no write exp write within 6 cycles"); end
    reset = 1'b1;
    bus0.hdr_valid = 1'b0; bus1.hdr_valid = 1'b0;
    bus0.pix_valid = 1'b0; bus1.pix_valid = 1'b0;
    #1;
    checks++; if (out0 !== '0) begin errors++; $display("FAIL rst_mid_rgb got %h exp 0", out0); end
    checks++; if (out1 !== '0) begin errors++; $display("FAIL rst_mid_gray got %h exp 0", out1); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_sb();
    drive_idle(5);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_discard got %0d exp 0", got_q.size()); end
    frame_begin(2, 2);
    repeat (4) rand_pix();
    frame_end();
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rst_mid_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_write%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    int w, h;
    for (int f = 0; f < 6; f++) begin
      clear_sb();
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      frame_begin(w, h);
      for (int i = 0; i < w * h; i++) begin
        rand_pix();
        if ($urandom_range(0, 2) == 0) drive_idle($urandom_range(1, 2));
      end
      frame_end();
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_write%0d got %h exp %h", f, i, got_q[i], exp_q[i]); end
      end
      checks++; if (bus1.frame_done !== 1'b1) begin errors++; $display("FAIL rand%0d_frame_done got %b exp 1", f, bus1.frame_done); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    bus0.pix_r = '0; bus0.pix_g = '0; bus0.pix_b = '0; bus0.pix_valid = 1'b0;
    bus0.width = '0; bus0.height = '0; bus0.hdr_valid = 1'b0;
    bus1.pix_r = '0; bus1.pix_g = '0; bus1.pix_b = '0; bus1.pix_valid = 1'b0;
    bus1.width = '0; bus1.height = '0; bus1.hdr_valid = 1'b0;
    test_reset();
    test_2x2();
    test_gray();
    test_back_to_back();
    test_surplus();
    test_bad_dims();
    test_reset_midframe();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
# frame_writer

Pixel sink that sits directly downstream of the byte-stream parser. It consumes the parser's latched image dimensions and its per-pixel R/G/B strobe, and tracks the raster position (x, y). It converts each pixel to RGB565 or 8-bit grayscale and issues one write per pixel into the frame memory at a linear address. It also flags start/end of line/frame, frame completion, and protocol errors (bad dimensions, surplus pixels).

## Interface
- `ADDR_W`, default 19: width of `wr_addr`.
- `MAX_PIXELS`, default 307200: largest accepted width×height (640×480).
- `GRAY`, default 0: output format. 0 = RGB565 in `wr_data[15:0]`. 1 = luma in `wr_data[7:0]` with `wr_data[15:8]` = 0.

- `clk` in 1: system clock; everything on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `pix_r`, `pix_g`, `pix_b` in 8 each: pixel components; valid only when `pix_valid` = 1.
- `pix_valid` in 1: one-cycle strobe, one pixel per assertion.
- `height` in 16: frame height in lines; stable while `hdr_valid` = 1.
- `width` in 16: frame width in pixels; stable while `hdr_valid` = 1.
- `hdr_valid` in 1: dimensions valid; level, stays high for the whole frame.
- `wr_en` out 1: memory write strobe.
- `wr_addr` out ADDR_W: linear pixel index, y×width + x.
- `wr_data` out 16: converted pixel.
- `sof` out 1: qualifies `wr_en`; marks the first pixel of the frame.
- `eol` out 1: qualifies `wr_en`; marks the last pixel of a line.
- `eof` out 1: qualifies `wr_en`; marks the last pixel of the frame.
- `frame_done` out 1: level; high from the `eof` write until the next frame starts.
- `dim_error` out 1: level; dimensions were zero or exceeded `MAX_PIXELS`.
- `overflow` out 1: sticky; a pixel arrived after `eof`.

## Operation
- States: IDLE, RUN, DONE, ERROR. Reset enters IDLE.
- **IDLE**
  - `pix_valid` is ignored and raises no flag.
  - On an edge with `hdr_valid` = 1:
    - Latch `width` and `height`.
    - Compute the 32-bit product width×height.
    - If width = 0, height = 0, or product > `MAX_PIXELS`: go to ERROR.
    - Otherwise: go to RUN, clear x, y, addr, `frame_done`, `overflow`.
- **RUN**, on each `pix_valid`:
  - Issue a write at the current addr, then addr += 1.
  - If x = width−1: x ← 0, y += 1, tag `eol`. Otherwise x += 1.
  - If x = width−1 and y = height−1: tag `eof` and go to DONE.
  - The first accepted pixel is tagged `sof`.
- **DONE**
  - `frame_done` = 1.
  - `pix_valid` produces no write and sets `overflow`.
- **ERROR**
  - `dim_error` = 1; no writes.
  - `pix_valid` sets `overflow`.
- Exit from RUN, DONE or ERROR:
  - `hdr_valid` low on any edge → IDLE.
  - `frame_done`, `dim_error` and `overflow` hold their values until the next frame starts (IDLE→RUN/ERROR).
  - A frame aborted in RUN leaves `frame_done` = 0.
- Conversion:
  - RGB565 = {r[7:3], g[7:2], b[7:3]}.
  - Luma = (77·r + 150·g + 29·b) >> 8. Use a 16-bit intermediate; the result is truncated to 8 bits and never exceeds 255.
- `wr_addr` is the low `ADDR_W` bits of addr. `MAX_PIXELS` ≤ 2^ADDR_W is the integrator's responsibility.

## Timing
- Reset values:
  - `wr_en`, `sof`, `eol`, `eof`, `frame_done`, `dim_error`, `overflow` = 0.
  - `wr_addr`, `wr_data` = 0.
- Latency: `pix_valid` sampled at edge N gives `wr_en` high for the cycle after edge N+2. That is a fixed 2-stage pipeline in both modes.
- Pipeline alignment:
  - `wr_addr`, `wr_data`, `sof`, `eol` and `eof` travel with their pixel.
  - All are valid only while `wr_en` = 1; they are 0 otherwise.
- `frame_done` rises in the same cycle as the `eof` write.
- `hdr_valid` rising edge: the IDLE→RUN decision is made on that edge, so a pixel one cycle later is accepted. The upstream parser provides at least a 2-cycle gap.
- Back-to-back `pix_valid` on every cycle is supported at full rate. There is no backpressure.
- `hdr_valid` falling while writes are in flight: the pipeline still drains its in-flight pixels.
- Asynchronous reset mid-frame:
  - Outputs go to their reset values immediately.
  - In-flight pixels are discarded.

## Test plan
- **2×2 frame, GRAY=0.** Pixels (FF,00,FF), (00,FF,00), (FF,FF,FF), (00,00,00) → four writes at addr 0..3 with data F81F, 07E0, FFFF, 0000. Flags:
  - `sof` on addr 0.
  - `eol` on addr 1 and 3.
  - `eof` on addr 3; `frame_done` = 1 from that cycle.
- **GRAY=1, 1×1 frame.** Pixel (FF,FF,FF) → `wr_data` = 00FF. Pixel (10,20,30) in a new frame → 001D.
- **3×2 frame, back-to-back pixels.** `wr_en` high for 6 consecutive cycles, 2 cycles after the first strobe. `eol` on addr 2 and 5.
- **Surplus pixel.** Extra `pix_valid` after `eof` of a 2×2 frame → no write, `overflow` = 1. `overflow` clears only at the next frame's start.
- **Bad dimensions.** width = 0, or 641×480 with default `MAX_PIXELS` → `dim_error` = 1, no `wr_en` for any following pixel.
- **Reset mid-frame.** Assert `reset` after 2 pixels of a 4×4 frame → all outputs 0 immediately. A fresh 2×2 frame then writes from addr 0 with `sof`.
